demux18_deser: RTL and testbench

- Serial-to-parallel 1:8 demultiplexer; the receive-side counterpart of the 8:1 bit-select mux.
- A 3-bit slot counter plays the role of the mux select. It steers each incoming serial bit into one of eight output positions.
- When a frame of 8 bits is complete, the block presents the whole byte on a parallel bus with a one-cycle valid strobe.
- Sits after any serialising 8:1 mux stage to rebuild the original i[0:7] vector.

---
 rtl/demux18_deser.sv | 107 ++++++++++
 tb/tb_demux18_deser.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/demux18_deser.sv
// 1:8 serial-to-parallel demux. A 3-bit slot counter steers each valid bit into the shadow word, and the whole word is published with a one-cycle strobe.
// Optional DEMUX18_PARITY_EN: a 9th odd-parity bit is collected per frame and reported on perr.
module demux18_deser #(
  parameter int unsigned MSB_FIRST = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d,
  input  logic       d_valid,
  input  logic       sync,
  output logic [0:7] y,
  output logic       y_valid,
  output logic [2:0] slot,
  output logic       busy
`ifdef DEMUX18_PARITY_EN
  ,
  output logic       perr
`endif
);

`ifdef DEMUX18_PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_PAR} state_t;
  logic       r_perr;
`else
  typedef enum logic [0:0] {S_IDLE, S_COLLECT} state_t;
`endif

  state_t     r_state;
  logic [0:7] r_shadow;
  logic [0:7] r_y;
  logic       r_y_valid;
  logic [2:0] r_slot;
  logic [2:0] w_pos;
  logic [2:0] w_pos0;
  logic [0:7] w_merged;
  logic [0:7] w_first;

  always_comb begin
    w_pos           = (MSB_FIRST != 0) ? (3'd7 - r_slot) : r_slot;
    w_pos0          = (MSB_FIRST != 0) ? 3'd7 : 3'd0;
    w_merged        = r_shadow;
    w_merged[w_pos] = d;
    w_first         = '0;
    w_first[w_pos0] = d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_shadow  <= '0;
      r_y       <= '0;
      r_y_valid <= 1'b0;
      r_slot    <= '0;
`ifdef DEMUX18_PARITY_EN
      r_perr    <= 1'b0;
`endif
    end else begin
      r_y_valid <= 1'b0;
      if (sync) begin
        // sync overrides any frame-completing bit in the same cycle
        if (d_valid) begin
          r_shadow <= w_first;
          r_slot   <= 3'd1;
          r_state  <= S_COLLECT;
        end else begin
          r_shadow <= '0;
          r_slot   <= '0;
          r_state  <= S_IDLE;
        end
      end else if (d_valid) begin
`ifdef DEMUX18_PARITY_EN
        if (r_state == S_PAR) begin
          r_y       <= r_shadow;
          r_y_valid <= 1'b1;
          r_perr    <= ~(^r_shadow ^ d);
          r_state   <= S_IDLE;
        end else
`endif
        begin
          // IDLE always has slot 0, so it shares the COLLECT write path
          r_shadow <= w_merged;
          r_slot   <= r_slot + 3'd1;
          if (r_slot == 3'd7) begin
`ifdef DEMUX18_PARITY_EN
            r_state   <= S_PAR;
`else
            r_y       <= w_merged;
            r_y_valid <= 1'b1;
            r_state   <= S_IDLE;
`endif
          end else begin
            r_state <= S_COLLECT;
          end
        end
      end
    end
  end

  assign y       = r_y;
  assign y_valid = r_y_valid;
  assign slot    = r_slot;
  assign busy    = (r_state != S_IDLE);
`ifdef DEMUX18_PARITY_EN
  assign perr    = r_perr;
`endif

endmodule

// File: tb/tb_demux18_deser.sv
// Self-checking bench for demux18_deser: LSB-first and MSB-first instances share stimulus and are checked against a bit-queue frame model.
module tb_demux18_deser;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, d, d_valid, sync;
  logic [0:7] y0, y1;
  logic       yv0, yv1, busy0, busy1;
  logic [2:0] slot0, slot1;
`ifdef DEMUX18_PARITY_EN
  logic       perr0, perr1;
  localparam int FLEN = 9;
`else
  localparam int FLEN = 8;
`endif

  demux18_deser #(.MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .sync(sync),
    .y(y0), .y_valid(yv0), .slot(slot0), .busy(busy0)
`ifdef DEMUX18_PARITY_EN
    , .perr(perr0)
`endif
  );

  demux18_deser #(.MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .sync(sync),
    .y(y1), .y_valid(yv1), .slot(slot1), .busy(busy1)
`ifdef DEMUX18_PARITY_EN
    , .perr(perr1)
`endif
  );

  int n_pass = 0;
  int n_total = 0;
  int pulses = 0;
  int cyc_n = 0;
  int last_pulse = 0;
  int pulse_gap = 0;

  // Reference model: bits of the current frame in arrival order
  bit         q[$];
  logic [0:7] m_y0, m_y1;
  logic       m_yv, m_perr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_step(input logic r, input logic dd, input logic dv, input logic s);
    int ones;
    m_yv = 1'b0;
    if (r) begin
      q.delete();
      m_y0 = '0; m_y1 = '0; m_perr = 1'b0;
    end else if (s) begin
      q.delete();
      if (dv) q.push_back(dd);
    end else if (dv) begin
      q.push_back(dd);
      if (q.size() == FLEN) begin
        ones = 0;
        for (int k = 0; k < 8; k++) begin
          m_y0[k]     = q[k];
          m_y1[7 - k] = q[k];
        end
        for (int k = 0; k < FLEN; k++) ones += int'(q[k]);
        m_perr = ((ones % 2) == 0);
        m_yv = 1'b1;
        q.delete();
      end
    end
  endtask

  task automatic cyc(input logic r, input logic dd, input logic dv, input logic s);
    rst = r; d = dd; d_valid = dv; sync = s;
    @(posedge clk);
    model_step(r, dd, dv, s);
    #1;
    cyc_n++;
    if (yv0 === 1'b1) begin
      pulses++;
      pulse_gap = cyc_n - last_pulse;
      last_pulse = cyc_n;
    end
    check("y_lsb", 32'(y0), 32'(m_y0));
    check("yv_lsb", 32'(yv0), 32'(m_yv));
    check("slot_lsb", 32'(slot0), 32'(q.size() % 8));
    check("busy_lsb", 32'(busy0), 32'(q.size() != 0));
    check("y_msb", 32'(y1), 32'(m_y1));
    check("yv_msb", 32'(yv1), 32'(m_yv));
    check("slot_msb", 32'(slot1), 32'(q.size() % 8));
    check("busy_msb", 32'(busy1), 32'(q.size() != 0));
`ifdef DEMUX18_PARITY_EN
    check("perr_lsb", 32'(perr0), 32'(m_perr));
    check("perr_msb", 32'(perr1), 32'(m_perr));
`endif
  endtask

  // Sends one frame (first bit = bits[0]); gap idle cycles are inserted after gap_at bits
  task automatic send_frame(input logic [0:7] bits, input logic par, input int gap_at, input int gap);
    for (int k = 0; k < 8; k++) begin
      if (k == gap_at) for (int g = 0; g < gap; g++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, bits[k], 1'b1, 1'b0);
    end
`ifdef DEMUX18_PARITY_EN
    cyc(1'b0, par, 1'b1, 1'b0);
`else
    if (par) ; // parity bit only exists when the feature is built in
`endif
  endtask

  typedef struct {
    logic       d, dv, s;
    logic [0:7] ey;
    logic       eyv;
    logic [2:0] eslot;
    logic       ebusy;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic dd, input logic dv, input logic s, input logic [0:7] ey,
                     input logic eyv, input logic [2:0] es, input logic eb);
    vec_t v;
    v.d = dd; v.dv = dv; v.s = s; v.ey = ey; v.eyv = eyv; v.eslot = es; v.ebusy = eb;
    tbl.push_back(v);
  endtask

  initial begin
    logic [0:7] fr;
    rst = 1'b1; d = 1'b0; d_valid = 1'b0; sync = 1'b0;

    // Reset two cycles, then idle
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);

`ifndef DEMUX18_PARITY_EN
    // Table: frame 10110010, then 5 bits + sync + 7 zeros
    fr = 8'b10110010;
    for (int k = 0; k < 7; k++) add(fr[k], 1'b1, 1'b0, 8'h00, 1'b0, 3'(k + 1), 1'b1);
    add(fr[7], 1'b1, 1'b0, 8'b10110010, 1'b1, 3'd0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 8'b10110010, 1'b0, 3'd0, 1'b0);
    for (int k = 0; k < 5; k++) add(1'b1, 1'b1, 1'b0, 8'b10110010, 1'b0, 3'(k + 1), 1'b1);
    add(1'b1, 1'b1, 1'b1, 8'b10110010, 1'b0, 3'd1, 1'b1);
    for (int k = 0; k < 6; k++) add(1'b0, 1'b1, 1'b0, 8'b10110010, 1'b0, 3'(k + 2), 1'b1);
    add(1'b0, 1'b1, 1'b0, 8'b10000000, 1'b1, 3'd0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 8'b10000000, 1'b0, 3'd0, 1'b0);
    for (int i = 0; i < tbl.size(); i++) begin
      rst = 1'b0; d = tbl[i].d; d_valid = tbl[i].dv; sync = tbl[i].s;
      @(posedge clk);
      model_step(1'b0, tbl[i].d, tbl[i].dv, tbl[i].s);
      #1;
      cyc_n++;
      check($sformatf("tbl%0d_y", i), 32'(y0), 32'(tbl[i].ey));
      check($sformatf("tbl%0d_yv", i), 32'(yv0), 32'(tbl[i].eyv));
      check($sformatf("tbl%0d_slot", i), 32'(slot0), 32'(tbl[i].eslot));
      check($sformatf("tbl%0d_busy", i), 32'(busy0), 32'(tbl[i].ebusy));
    end
`endif

    // Gapped frame: 3 idle cycles between bits 4 and 5, one pulse
    pulses = 0;
    send_frame(8'b10110010, 1'b1, 4, 3);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("gap_pulses", 32'(pulses), 32'd1);
    check("gap_y", 32'(y0), 32'(8'b10110010));

    // Back-to-back frames, pulses exactly one frame length apart
    pulses = 0;
    send_frame(8'b11110000, 1'b1, 8, 0);
    send_frame(8'b00001111, 1'b1, 8, 0);
    check("b2b_pulses", 32'(pulses), 32'd2);
    check("b2b_spacing", 32'(pulse_gap), 32'(FLEN));
    check("b2b_y", 32'(y0), 32'(8'b00001111));

    // Reset mid-frame discards the partial frame
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    pulses = 0;
    for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_pulses", 32'(pulses), 32'd0);
    check("rst_y", 32'(y0), 32'd0);

    // MSB-first single bit
    send_frame(8'b10000000, 1'b0, 8, 0);
    check("msb_y", 32'(y1), 32'(8'b00000001));

    // sync on the frame-completing data bit wins
    pulses = 0;
    for (int k = 0; k < 7; k++) cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    check("sync_last_pulses", 32'(pulses), 32'd0);
    // sync without data returns to idle
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("sync_idle_busy", 32'(busy0), 32'd0);

`ifdef DEMUX18_PARITY_EN
    // Parity: good, bad, and sync during the parity slot
    send_frame(8'b10110010, 1'b1, 8, 0);
    check("par_good", 32'(perr0), 32'd0);
    send_frame(8'b10110010, 1'b0, 8, 0);
    check("par_bad", 32'(perr0), 32'd1);
    pulses = 0;
    for (int k = 0; k < 8; k++) cyc(1'b0, k[0], 1'b1, 1'b0);
    check("par_8th_no_pulse", 32'(pulses), 32'd0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    check("par_sync_pulses", 32'(pulses), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
`endif

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      cyc((($urandom_range(0, 199)) == 0) ? 1'b1 : 1'b0,
          1'($urandom_range(0, 1)),
          ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
          ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
